// File: rtl/rr_burst_arbiter.sv
// rr_burst_arbiter
//   Round-robin arbiter with burst locking. It forwards one message per cycle
//   from N_INPUTS requesters into a single registered output entry.
//   Once a requester wins, it keeps the grant for up to MAX_BURST back-to-back
//   transfers while its valid stays high. After that the round-robin pointer
//   moves past it.
//
// Ports
//   clk       clock; all state updates on the rising edge
//   reset     asynchronous, active-low reset
//   recv_val  [N_INPUTS]            per-requester valid
//   recv_rdy  [N_INPUTS]            per-requester ready (one-hot or zero)
//   recv_msg  [0:N_INPUTS-1][BIT_WIDTH] per-requester payload
//   send_val                        output entry full
//   send_rdy                        downstream ready
//   send_msg  [BIT_WIDTH+ADDR_BITS] {source index, payload}
module rr_burst_arbiter #(
    parameter int BIT_WIDTH = 32,
    parameter int N_INPUTS  = 16,
    parameter int MAX_BURST = 4,
    localparam int ADDR_BITS = $clog2(N_INPUTS),
    localparam int CNT_BITS  = $clog2(MAX_BURST + 1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [N_INPUTS-1:0]            recv_val,
    output logic [N_INPUTS-1:0]            recv_rdy,
    input  logic [BIT_WIDTH-1:0]           recv_msg [0:N_INPUTS-1],
    output logic                           send_val,
    input  logic                           send_rdy,
    output logic [BIT_WIDTH+ADDR_BITS-1:0] send_msg
);

    // arbitration state
    logic                 locked, locked_n;
    logic [ADDR_BITS-1:0] owner, owner_n;
    logic [ADDR_BITS-1:0] ptr, ptr_n;
    logic [CNT_BITS-1:0]  burst_cnt, cnt_n;

    // output entry
    logic                           out_full;
    logic [BIT_WIDTH+ADDR_BITS-1:0] out_msg;

    logic                 load_en, accept;
    logic                 hold_owner, grant_vld;
    logic [ADDR_BITS-1:0] grant, base, cand;
    logic [CNT_BITS-1:0]  cnt_inc;

    assign load_en = !out_full || send_rdy;
    assign accept  = load_en && grant_vld;

    // Grant select. A lock whose owner has dropped valid is dissolved in the
    // same cycle, so the search resumes just past the owner with no bubble.
    always_comb begin
        grant      = '0;
        grant_vld  = 1'b0;
        cand       = '0;
        hold_owner = locked && recv_val[owner];
        base       = locked ? owner + ADDR_BITS'(1) : ptr;
        if (hold_owner) begin
            grant     = owner;
            grant_vld = 1'b1;
        end else begin
            for (int k = 0; k < N_INPUTS; k++) begin
                // N_INPUTS is a power of 2, so the add wraps naturally
                cand = base + ADDR_BITS'(k);
                if (!grant_vld && recv_val[cand]) begin
                    grant     = cand;
                    grant_vld = 1'b1;
                end
            end
        end
    end

    // Next-state logic
    always_comb begin
        locked_n = locked;
        owner_n  = owner;
        ptr_n    = ptr;
        cnt_n    = burst_cnt;
        // transfer count including this one; the lock is held with burst_cnt
        // at most MAX_BURST-1, so the increment cannot overflow
        cnt_inc  = hold_owner ? burst_cnt + CNT_BITS'(1) : CNT_BITS'(1);
        if (accept) begin
            if (cnt_inc < CNT_BITS'(MAX_BURST)) begin
                locked_n = 1'b1;
                owner_n  = grant;
                cnt_n    = cnt_inc;
            end else begin
                locked_n = 1'b0;
                ptr_n    = grant + ADDR_BITS'(1);
                cnt_n    = '0;
            end
        end else if (load_en && locked && !recv_val[owner]) begin
            locked_n = 1'b0;
            ptr_n    = owner + ADDR_BITS'(1);
            cnt_n    = '0;
        end
    end

    // State and output register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            locked    <= 1'b0;
            owner     <= '0;
            ptr       <= '0;
            burst_cnt <= '0;
            out_full  <= 1'b0;
            out_msg   <= '0;
        end else begin
            locked    <= locked_n;
            owner     <= owner_n;
            ptr       <= ptr_n;
            burst_cnt <= cnt_n;
            if (accept) begin
                out_full <= 1'b1;
                out_msg  <= {grant, recv_msg[grant]};
            end else if (send_rdy) begin
                out_full <= 1'b0;
            end
        end
    end

    // Outputs. recv_rdy is gated by reset so that it is low for the whole
    // reset interval, not only once the register has cleared.
    always_comb begin
        send_val = out_full;
        send_msg = out_msg;
        for (int i = 0; i < N_INPUTS; i++)
            recv_rdy[i] = reset && accept && (grant == ADDR_BITS'(i));
    end

endmodule

// File: tb/tb_rr_burst_arbiter.sv
module tb_rr_burst_arbiter;

    localparam int BW = 32;
    localparam int N  = 16;
    localparam int AB = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      recv_val;
    logic [N-1:0]      recv_rdy;
    logic [BW-1:0]     recv_msg [0:N-1];
    logic              send_val;
    logic              send_rdy;
    logic [BW+AB-1:0]  send_msg;

    int total = 0;
    int bad   = 0;

    rr_burst_arbiter #(.BIT_WIDTH(BW), .N_INPUTS(N), .MAX_BURST(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .recv_val (recv_val),
        .recv_rdy (recv_rdy),
        .recv_msg (recv_msg),
        .send_val (send_val),
        .send_rdy (send_rdy),
        .send_msg (send_msg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] pay(input int s);
        return 32'hA500_0000 | 32'(s);
    endfunction

    function automatic logic [BW+AB-1:0] em(input int s);
        logic [AB-1:0] idx;
        idx = s[AB-1:0];
        return {idx, pay(s)};
    endfunction

    function automatic logic [N-1:0] bit1(input int s);
        logic [N-1:0] v;
        v = '0;
        v[s] = 1'b1;
        return v;
    endfunction

    // advance to just after the next rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // reset released mid-cycle, away from the clock edge
    task automatic do_reset();
        recv_val = '0;
        send_rdy = 1'b1;
        for (int i = 0; i < N; i++) recv_msg[i] = pay(i);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
    endtask

    initial begin
        reset    = 1'b0;
        send_rdy = 1'b0;
        recv_val = '0;
        for (int i = 0; i < N; i++) recv_msg[i] = pay(i);

        // reset state, single transfer from requester 3
        #2;
        recv_val    = bit1(3);
        recv_msg[3] = 32'hDEAD_BEEF;
        send_rdy    = 1'b1;
        #1;
        chk("rst_rdy", 64'(recv_rdy), 64'(0));
        chk("rst_sval", 64'(send_val), 64'(0));
        chk("rst_smsg", 64'(send_msg), 64'(0));
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t1_rdy", 64'(recv_rdy), 64'(bit1(3)));
        chk("t1_sval0", 64'(send_val), 64'(0));
        cyc();
        chk("t1_sval1", 64'(send_val), 64'(1));
        chk("t1_smsg", 64'(send_msg), 64'h3_DEAD_BEEF);
        recv_val = '0;
        cyc();
        chk("t1_drain", 64'(send_val), 64'(0));

        // alternating bursts between 2 and 5
        begin
            int exp_src [10] = '{2, 2, 2, 2, 5, 5, 5, 5, 2, 2};
            do_reset();
            recv_val = bit1(2) | bit1(5);
            #1;
            chk("t2_rdy0", 64'(recv_rdy), 64'(bit1(2)));
            for (int k = 0; k < 10; k++) begin
                cyc();
                chk($sformatf("t2_seq%0d", k), 64'(send_msg), 64'(em(exp_src[k])));
            end
        end

        // 7 sends two and drops; 9 follows with no idle cycle
        do_reset();
        recv_val = bit1(7) | bit1(9);
        cyc();
        chk("t3_a0", 64'(send_msg), 64'(em(7)));
        cyc();
        chk("t3_a1", 64'(send_msg), 64'(em(7)));
        recv_val = bit1(9);
        #1;
        chk("t3_rdy", 64'(recv_rdy), 64'(bit1(9)));
        cyc();
        chk("t3_val", 64'(send_val), 64'(1));
        chk("t3_a2", 64'(send_msg), 64'(em(9)));

        // backpressure: stall for 5 cycles, then drain and load together
        do_reset();
        recv_val = bit1(1) | bit1(2) | bit1(3);
        cyc();
        chk("t4_a0", 64'(send_msg), 64'(em(1)));
        send_rdy = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t4_rdy%0d", k), 64'(recv_rdy), 64'(0));
            cyc();
            chk($sformatf("t4_hold%0d", k), 64'(send_msg), 64'(em(1)));
        end
        recv_msg[1] = 32'h1234_5678;
        send_rdy    = 1'b1;
        #1;
        chk("t4_rel_rdy", 64'(recv_rdy), 64'(bit1(1)));
        cyc();
        chk("t4_rel_val", 64'(send_val), 64'(1));
        chk("t4_rel_msg", 64'(send_msg), 64'h1_1234_5678);

        // wrap-around: burst from 15 then 0 wins over 1
        do_reset();
        recv_val = bit1(15);
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk($sformatf("t5_15_%0d", k), 64'(send_msg), 64'(em(15)));
        end
        recv_val = bit1(0) | bit1(1);
        #1;
        chk("t5_rdy", 64'(recv_rdy), 64'(bit1(0)));
        cyc();
        chk("t5_a0", 64'(send_msg), 64'(em(0)));

        // async reset during a lock with the output full
        do_reset();
        recv_val = bit1(4);
        cyc();
        chk("t6_a0", 64'(send_msg), 64'(em(4)));
        send_rdy = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("t6_sval", 64'(send_val), 64'(0));
        chk("t6_rdy", 64'(recv_rdy), 64'(0));
        chk("t6_smsg", 64'(send_msg), 64'(0));
        cyc();
        recv_val = bit1(1) | bit1(4);
        #2 reset = 1'b1;
        #1;
        chk("t6_rel_sval", 64'(send_val), 64'(0));
        chk("t6_rel_rdy", 64'(recv_rdy), 64'(bit1(1)));
        cyc();
        chk("t6_a1", 64'(send_msg), 64'(em(1)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
